egrs_spim_dir_arbiter: RTL and testbench
========================================

// Module: egrs_spim_dir_arbiter
// PURPOSE
//  Shares the egress SPI master bridge direct AVMM slave between two requesters: req0 = PCIe VDM
//  buffer egress master (bursting), req1 = NIOS management master. Round-robin arbitration, one
//  transaction in flight; whole bursts are atomic. pulse_1ms watchdog recovers a hung slave.
// PARAMETERS
//  ADDR_WIDTH  12   word address width (matches bridge DIR_ADDR_WIDTH)
//  DATA_WIDTH  32   data width
//  BRST_WIDTH  9    burstcount width
//  TIMEOUT_MS  4    pulse_1ms ticks without progress before abort (>=1)
// PORTS
//  clk             in   1           system clock
//  reset           in   1           synchronous, active-high
//  pulse_1ms       in   1           1-cycle tick
//  rN_addr         in   ADDR_WIDTH  requester N (N=0,1) address
//  rN_write/read   in   1           requester N command
//  rN_burstcnt     in   BRST_WIDTH  requester N burst length
//  rN_wrdata       in   DATA_WIDTH  requester N write data
//  rN_rddata       out  DATA_WIDTH  requester N read data
//  rN_rddvld       out  1           requester N read data valid
//  rN_waitreq      out  1           requester N wait request
//  s_addr/s_write/s_read/s_burstcnt/s_wrdata  out  -  to bridge avmm_dir_* (same widths)
//  s_rddata/s_rddvld/s_waitreq                in   -  from bridge
//  err_timeout     out  1           sticky abort flag, cleared by reset only
//  gnt_id          out  1           currently/last granted requester
// BEHAVIOUR
//  Reset: state IDLE, rN_waitreq=1, rN_rddvld=0, rN_rddata=0, s_write=s_read=0, s_addr/
//   s_burstcnt/s_wrdata=0, err_timeout=0, gnt_id=1 (so req0 wins first tie). Reset mid-burst aborts
//   immediately; no residual beats are driven.
//  FSM IDLE -> WR_BURST | RD_CMD -> RD_DATA -> IDLE.
//  IDLE: rN_waitreq=1 for both; request = rN_write|rN_read. One request -> grant it; both -> grant
//   !gnt_id. Grant registered: command reaches s_* the cycle after request is first sampled.
//   Write and read asserted together: write takes priority.
//  Burstcnt latched at grant; value 0 treated as 1. Beat counter is BRST_WIDTH+1 bits.
//  WR_BURST: s_* driven combinationally from granted requester; granted rN_waitreq = s_waitreq,
//   other = 1. Beat accepted on s_write & !s_waitreq; after last beat -> IDLE next cycle
//   (s_write deasserted; a new grant needs >=1 IDLE cycle).
//  RD_CMD: s_read=1 with granted addr/burstcnt; granted rN_waitreq=s_waitreq. On accept -> RD_DATA;
//   s_read=0 and both rN_waitreq=1 from then on.
//  RD_DATA: s_rddvld/s_rddata routed to granted requester only (other rddvld=0, rddata=0); count
//   beats; last beat -> IDLE. s_rddvld outside RD_DATA is ignored.
//  Watchdog: counts pulse_1ms in WR_BURST/RD_CMD/RD_DATA; cleared on each accepted beat and on state
//   change. Reaching TIMEOUT_MS: set err_timeout; WR_BURST/RD_CMD -> drop s_write/s_read, IDLE;
//   RD_DATA -> drive remaining rddvld beats to requester, one per cycle, rddata=0, then IDLE.
//  Simultaneous last beat and timeout tick: beat wins, no error.
//  Non-granted requester commands are held off, never dropped.
// TESTING
//  1. r0 write burst 4 @0x010, s_waitreq=0 -> 4 s_write beats, data in order, r1 waitreq=1 throughout.
//  2. r0,r1 reads same cycle after reset -> r0 granted first, r1 next; rddvld only to owner.
//  3. Back-to-back r0 requests while r1 pending -> alternation r0,r1,r0 (round-robin).
//  4. r1 read burstcnt=0 -> single s_read with s_burstcnt=0, one rddvld beat returned, IDLE.
//  5. r0 read burst 8, slave returns 3 beats then stalls, TIMEOUT_MS=4 -> after 4 ticks err_timeout=1,
//     5 beats rddata=0 to r0, IDLE; r1 served next.
//  6. Reset during write beat 2 of 4 -> next cycle all outputs at reset values, gnt_id=1.

Source files
------------

// File: rtl/egrs_spim_dir_arbiter.sv
// Two-requester round-robin arbiter in front of the egress SPI master bridge direct AVMM slave.
// One transaction in flight, bursts atomic, pulse_1ms watchdog aborts a hung slave.
module egrs_spim_dir_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BRST_WIDTH = 9,
  parameter int TIMEOUT_MS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pulse_1ms,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r0_write,
  input  logic                  r0_read,
  input  logic [BRST_WIDTH-1:0] r0_burstcnt,
  input  logic [DATA_WIDTH-1:0] r0_wrdata,
  output logic [DATA_WIDTH-1:0] r0_rddata,
  output logic                  r0_rddvld,
  output logic                  r0_waitreq,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic                  r1_write,
  input  logic                  r1_read,
  input  logic [BRST_WIDTH-1:0] r1_burstcnt,
  input  logic [DATA_WIDTH-1:0] r1_wrdata,
  output logic [DATA_WIDTH-1:0] r1_rddata,
  output logic                  r1_rddvld,
  output logic                  r1_waitreq,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_write,
  output logic                  s_read,
  output logic [BRST_WIDTH-1:0] s_burstcnt,
  output logic [DATA_WIDTH-1:0] s_wrdata,
  input  logic [DATA_WIDTH-1:0] s_rddata,
  input  logic                  s_rddvld,
  input  logic                  s_waitreq,
  output logic                  err_timeout,
  output logic                  gnt_id
);

  localparam int CW   = BRST_WIDTH + 1;
  localparam int WD_W = $clog2(TIMEOUT_MS + 1);

  // ST_RD_FLUSH drains the undelivered beats of a read aborted by the watchdog.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_RD_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  logic                  req0, req1, pick;
  logic                  sel_write;
  logic [BRST_WIDTH-1:0] sel_burst;
  logic                  g_write;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [BRST_WIDTH-1:0] g_burst;
  logic [DATA_WIDTH-1:0] g_wrdata;
  logic                  beat, last_beat, wd_expire, busy;

  assign req0 = r0_write | r0_read;
  assign req1 = r1_write | r1_read;
  // A tie goes to the requester that was not granted last.
  assign pick      = (req0 & req1) ? ~gnt_q : req1;
  assign sel_write = pick ? r1_write : r0_write;
  assign sel_burst = pick ? r1_burstcnt : r0_burstcnt;

  assign g_write  = gnt_q ? r1_write : r0_write;
  assign g_addr   = gnt_q ? r1_addr : r0_addr;
  assign g_burst  = gnt_q ? r1_burstcnt : r0_burstcnt;
  assign g_wrdata = gnt_q ? r1_wrdata : r0_wrdata;

  assign last_beat = (beat_q + CW'(1)) == len_q;
  assign wd_expire = pulse_1ms && (wd_q == WD_W'(TIMEOUT_MS - 1));
  assign busy      = (state_q == ST_WR_BURST) || (state_q == ST_RD_CMD) ||
                     (state_q == ST_RD_DATA);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q;
    beat       = 1'b0;
    s_addr     = '0;
    s_write    = 1'b0;
    s_read     = 1'b0;
    s_burstcnt = '0;
    s_wrdata   = '0;
    r0_waitreq = 1'b1;
    r1_waitreq = 1'b1;
    r0_rddvld  = 1'b0;
    r1_rddvld  = 1'b0;
    r0_rddata  = '0;
    r1_rddata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          len_d   = (sel_burst == '0) ? CW'(1) : {1'b0, sel_burst};
          beat_d  = '0;
          state_d = sel_write ? ST_WR_BURST : ST_RD_CMD;
        end
      end
      ST_WR_BURST: begin
        s_write    = g_write;
        s_addr     = g_addr;
        s_burstcnt = g_burst;
        s_wrdata   = g_wrdata;
        if (gnt_q) r1_waitreq = s_waitreq;
        else       r0_waitreq = s_waitreq;
        beat = g_write & ~s_waitreq;
        if (beat) begin
          beat_d = beat_q + CW'(1);
          if (last_beat) state_d = ST_IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_CMD: begin
        s_read     = 1'b1;
        s_addr     = g_addr;
        s_burstcnt = g_burst;
        if (gnt_q) r1_waitreq = s_waitreq;
        else       r0_waitreq = s_waitreq;
        if (!s_waitreq) begin
          state_d = ST_RD_DATA;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_DATA: begin
        if (gnt_q) begin
          r1_rddvld = s_rddvld;
          r1_rddata = s_rddata;
        end else begin
          r0_rddvld = s_rddvld;
          r0_rddata = s_rddata;
        end
        beat = s_rddvld;
        if (beat) begin
          beat_d = beat_q + CW'(1);
          if (last_beat) state_d = ST_IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_RD_FLUSH;
        end
      end
      ST_RD_FLUSH: begin
        if (gnt_q) r1_rddvld = 1'b1;
        else       r0_rddvld = 1'b1;
        beat_d = beat_q + CW'(1);
        if (last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog restarts on progress; it only runs while waiting on the slave.
    if ((state_d != state_q) || beat) wd_d = '0;
    else if (pulse_1ms && busy)       wd_d = wd_q + WD_W'(1);
    else                              wd_d = wd_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b1;
      len_q   <= '0;
      beat_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign err_timeout = err_q;
  assign gnt_id      = gnt_q;

endmodule

// File: tb/tb_egrs_spim_dir_arbiter.sv
// Directed bench for egrs_spim_dir_arbiter: inputs change 1 ns after posedge,
// outputs are checked 2 ns after posedge.
module tb_egrs_spim_dir_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          pulse_1ms;
  logic [AW-1:0] r0_addr, r1_addr;
  logic          r0_write, r0_read, r1_write, r1_read;
  logic [BW-1:0] r0_burstcnt, r1_burstcnt;
  logic [DW-1:0] r0_wrdata, r1_wrdata;
  logic [DW-1:0] r0_rddata, r1_rddata;
  logic          r0_rddvld, r1_rddvld, r0_waitreq, r1_waitreq;
  logic [AW-1:0] s_addr;
  logic          s_write, s_read;
  logic [BW-1:0] s_burstcnt;
  logic [DW-1:0] s_wrdata, s_rddata;
  logic          s_rddvld, s_waitreq;
  logic          err_timeout, gnt_id;

  int n_vec = 0;
  int n_err = 0;

  egrs_spim_dir_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRST_WIDTH(BW), .TIMEOUT_MS(4)
  ) dut (
    .clk(clk), .reset(reset), .pulse_1ms(pulse_1ms),
    .r0_addr(r0_addr), .r0_write(r0_write), .r0_read(r0_read), .r0_burstcnt(r0_burstcnt),
    .r0_wrdata(r0_wrdata), .r0_rddata(r0_rddata), .r0_rddvld(r0_rddvld), .r0_waitreq(r0_waitreq),
    .r1_addr(r1_addr), .r1_write(r1_write), .r1_read(r1_read), .r1_burstcnt(r1_burstcnt),
    .r1_wrdata(r1_wrdata), .r1_rddata(r1_rddata), .r1_rddvld(r1_rddvld), .r1_waitreq(r1_waitreq),
    .s_addr(s_addr), .s_write(s_write), .s_read(s_read), .s_burstcnt(s_burstcnt),
    .s_wrdata(s_wrdata), .s_rddata(s_rddata), .s_rddvld(s_rddvld), .s_waitreq(s_waitreq),
    .err_timeout(err_timeout), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] wdat(input int i);
    return 32'hA500_0000 | DW'(i);
  endfunction

  // Serve one single-beat read: wait for the command, check the owner, return one beat.
  task automatic serve_one(input logic exp_who, input string tag);
    int  n = 0;
    logic who;
    while (s_read !== 1'b1 && n < 16) begin
      step;
      #1;
      n++;
    end
    if (s_read !== 1'b1) begin
      check({tag, "_cmd_wait"}, 64'd0, 64'd1);
      return;
    end
    who = (s_addr == r1_addr);
    check({tag, "_owner"}, 64'(who), 64'(exp_who));
    check({tag, "_gnt_id"}, 64'(gnt_id), 64'(exp_who));
    step;
    if (exp_who) r1_read = 1'b0;
    else         r0_read = 1'b0;
    s_rddvld = 1'b1;
    s_rddata = 32'hC0DE_0000 | DW'(exp_who);
    #1;
    check({tag, "_own_vld"}, 64'(exp_who ? r1_rddvld : r0_rddvld), 64'd1);
    check({tag, "_oth_vld"}, 64'(exp_who ? r0_rddvld : r1_rddvld), 64'd0);
    step;
    s_rddvld = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pulse_1ms = 1'b0;
    r0_addr = '0; r0_write = 1'b0; r0_read = 1'b0; r0_burstcnt = '0; r0_wrdata = '0;
    r1_addr = '0; r1_write = 1'b0; r1_read = 1'b0; r1_burstcnt = '0; r1_wrdata = '0;
    s_rddata = '0; s_rddvld = 1'b0; s_waitreq = 1'b0;
    step; step;
    reset = 1'b0;
    #1;
    check("rst_r0_waitreq", 64'(r0_waitreq), 64'd1);
    check("rst_r1_waitreq", 64'(r1_waitreq), 64'd1);
    check("rst_s_write", 64'(s_write), 64'd0);
    check("rst_s_read", 64'(s_read), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    check("rst_gnt_id", 64'(gnt_id), 64'd1);
    check("rst_err", 64'(err_timeout), 64'd0);

    // 1: r0 write burst of 4, one waitreq stall on the first beat.
    r0_addr = 12'h010; r0_burstcnt = 9'd4; r0_wrdata = wdat(0); r0_write = 1'b1;
    #1;
    check("t1_idle_waitreq", 64'(r0_waitreq), 64'd1);
    check("t1_idle_s_write", 64'(s_write), 64'd0);
    step;
    s_waitreq = 1'b1;
    #1;
    check("t1_stall_s_write", 64'(s_write), 64'd1);
    check("t1_stall_waitreq", 64'(r0_waitreq), 64'd1);
    step;
    s_waitreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r0_wrdata = wdat(i);
      #1;
      check($sformatf("t1_b%0d_s_write", i), 64'(s_write), 64'd1);
      check($sformatf("t1_b%0d_addr", i), 64'(s_addr), 64'h010);
      check($sformatf("t1_b%0d_data", i), 64'(s_wrdata), 64'(wdat(i)));
      check($sformatf("t1_b%0d_r0_wr", i), 64'(r0_waitreq), 64'd0);
      check($sformatf("t1_b%0d_r1_wr", i), 64'(r1_waitreq), 64'd1);
      step;
    end
    #1;
    check("t1_done_s_write", 64'(s_write), 64'd0);
    check("t1_done_waitreq", 64'(r0_waitreq), 64'd1);
    check("t1_gnt_id", 64'(gnt_id), 64'd0);
    r0_write = 1'b0;

    // 2: both read right after reset; r0 first, then r1.
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    r0_addr = 12'h100; r0_burstcnt = 9'd2; r0_read = 1'b1;
    r1_addr = 12'h200; r1_burstcnt = 9'd1; r1_read = 1'b1;
    s_rddvld = 1'b1; s_rddata = 32'hDEAD_BEEF;
    #1;
    check("t2_idle_vld_ignored", 64'(r0_rddvld), 64'd0);
    s_rddvld = 1'b0;
    step;
    #1;
    check("t2_s_read", 64'(s_read), 64'd1);
    check("t2_s_addr", 64'(s_addr), 64'h100);
    check("t2_s_burstcnt", 64'(s_burstcnt), 64'd2);
    check("t2_gnt_id", 64'(gnt_id), 64'd0);
    check("t2_r0_waitreq", 64'(r0_waitreq), 64'd0);
    check("t2_r1_waitreq", 64'(r1_waitreq), 64'd1);
    step;
    r0_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_rddvld = 1'b1; s_rddata = 32'h1111_0000 | DW'(i);
      #1;
      check($sformatf("t2_b%0d_s_read", i), 64'(s_read), 64'd0);
      check($sformatf("t2_b%0d_r0_vld", i), 64'(r0_rddvld), 64'd1);
      check($sformatf("t2_b%0d_r0_data", i), 64'(r0_rddata), 64'(32'h1111_0000 | i));
      check($sformatf("t2_b%0d_r1_vld", i), 64'(r1_rddvld), 64'd0);
      check($sformatf("t2_b%0d_r1_data", i), 64'(r1_rddata), 64'd0);
      step;
    end
    s_rddvld = 1'b0;
    #1;
    check("t2_gap_s_read", 64'(s_read), 64'd0);
    serve_one(1'b1, "t2_r1");

    // 3: r0 re-requests back-to-back while r1 waits -> r0, r1, r0.
    r0_addr = 12'h300; r0_burstcnt = 9'd1; r0_read = 1'b1; r1_read = 1'b1;
    #1;
    serve_one(1'b0, "t3_a");
    r0_read = 1'b1;
    serve_one(1'b1, "t3_b");
    serve_one(1'b0, "t3_c");

    // 4: r1 read with burstcnt 0 behaves as a single beat.
    r1_addr = 12'h2F0; r1_burstcnt = 9'd0; r1_read = 1'b1;
    #1;
    step;
    #1;
    check("t4_s_read", 64'(s_read), 64'd1);
    check("t4_s_burstcnt", 64'(s_burstcnt), 64'd0);
    check("t4_gnt_id", 64'(gnt_id), 64'd1);
    step;
    r1_read = 1'b0; s_rddvld = 1'b1; s_rddata = 32'h0000_4444;
    #1;
    check("t4_r1_vld", 64'(r1_rddvld), 64'd1);
    check("t4_r1_data", 64'(r1_rddata), 64'h4444);
    step;
    #1;
    check("t4_single_beat", 64'(r1_rddvld), 64'd0);
    s_rddvld = 1'b0;

    // 5: r0 read of 8, slave stalls after 3 beats; watchdog flushes 5 zero beats.
    r0_addr = 12'h080; r0_burstcnt = 9'd8; r0_read = 1'b1;
    r1_addr = 12'h200; r1_burstcnt = 9'd1; r1_read = 1'b1;
    #1;
    step;
    #1;
    check("t5_gnt_id", 64'(gnt_id), 64'd0);
    check("t5_s_burstcnt", 64'(s_burstcnt), 64'd8);
    step;
    r0_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_rddvld = 1'b1; s_rddata = 32'h5550 | DW'(i);
      #1;
      check($sformatf("t5_b%0d_data", i), 64'(r0_rddata), 64'(32'h5550 | i));
      step;
    end
    s_rddvld = 1'b0; s_rddata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      pulse_1ms = 1'b1;
      #1;
      check($sformatf("t5_tick%0d_err", k), 64'(err_timeout), 64'd0);
      check($sformatf("t5_tick%0d_vld", k), 64'(r0_rddvld), 64'd0);
      step;
      pulse_1ms = 1'b0;
      if (k < 3) begin
        #1;
        step;
      end
    end
    for (int j = 0; j < 5; j++) begin
      #1;
      check($sformatf("t5_f%0d_err", j), 64'(err_timeout), 64'd1);
      check($sformatf("t5_f%0d_vld", j), 64'(r0_rddvld), 64'd1);
      check($sformatf("t5_f%0d_data", j), 64'(r0_rddata), 64'd0);
      check($sformatf("t5_f%0d_r1_vld", j), 64'(r1_rddvld), 64'd0);
      step;
    end
    #1;
    check("t5_flush_end_vld", 64'(r0_rddvld), 64'd0);
    check("t5_flush_end_s_read", 64'(s_read), 64'd0);
    serve_one(1'b1, "t5_r1");
    check("t5_err_sticky", 64'(err_timeout), 64'd1);

    // 6: reset during write beat 2 of 4.
    r0_addr = 12'h040; r0_burstcnt = 9'd4; r0_wrdata = wdat(0); r0_write = 1'b1;
    #1;
    step;
    #1;
    check("t6_b0_s_write", 64'(s_write), 64'd1);
    step;
    r0_wrdata = wdat(1);
    #1;
    check("t6_b1_data", 64'(s_wrdata), 64'(wdat(1)));
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
    check("t6_s_write", 64'(s_write), 64'd0);
    check("t6_s_addr", 64'(s_addr), 64'd0);
    check("t6_s_wrdata", 64'(s_wrdata), 64'd0);
    check("t6_s_burstcnt", 64'(s_burstcnt), 64'd0);
    check("t6_r0_waitreq", 64'(r0_waitreq), 64'd1);
    check("t6_r1_waitreq", 64'(r1_waitreq), 64'd1);
    check("t6_gnt_id", 64'(gnt_id), 64'd1);
    check("t6_err", 64'(err_timeout), 64'd0);
    r0_write = 1'b0;
    step;
    #1;
    check("t6_no_residual", 64'(s_write), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
